// File: rtl/sseg_pkg.sv
// Shared definitions for the signed multiplexed 7-segment driver:
// glyph constants, BCD-to-glyph mapping, decimal digit count helper, FSM states.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Decimal digits needed for 2^(width-1), the largest magnitude of a signed width-bit value.
    function automatic int calc_nb(input int width);
        int v;
        int n;
        v = 32'sd1 << (width - 32'sd1);
        n = 32'sd0;
        for (int i = 0; i < 10; i++) begin
            if (v > 32'sd0) begin
                v = v / 32'sd10;
                n = n + 32'sd1;
            end else begin
                n = n;
            end
        end
        if (n < 32'sd1) begin
            n = 32'sd1;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/sseg_bin2bcd.sv
// Sequential double-dabble: loads on start, performs WIDTH add-3/shift steps,
// then pulses done for one cycle with the BCD result stable on bcd.
module sseg_bin2bcd
    import sseg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [WIDTH-1:0]                bin,
    output logic [4*calc_nb(WIDTH)-1:0]     bcd,
    output logic                            done
);

    localparam int NB = calc_nb(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  r_sh;
    logic [4*NB-1:0]   r_bcd;
    logic [4*NB-1:0]   w_adj;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;

    // Add 3 to every BCD digit that is 5 or more before the next shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NB; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    // Load, shift sequencing and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= {WIDTH{1'b0}};
            r_bcd  <= {(4*NB){1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_sh   <= bin;
            r_bcd  <= {(4*NB){1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            {r_bcd, r_sh} <= {w_adj[4*NB-2:0], r_sh, 1'b0};
            r_cnt         <= r_cnt + CW'(1'b1);
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;

endmodule

// File: rtl/sseg_signed_mux.sv
// Signed value to multiplexed common-anode 7-segment display driver.
// Optional macro SSEG_LZ_BLANK_EN: leading-zero blanking with a floating minus sign.
module sseg_signed_mux
    import sseg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int NB = calc_nb(WIDTH);
    localparam int CW = $clog2(WIDTH);
    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DIGITS);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_ready;
    logic [CW-1:0]     r_shift_cnt;
    logic              w_accept;
    logic              w_neg;
    logic [WIDTH-1:0]  w_mag;
    logic              r_neg_pend;
    logic [4*NB-1:0]   w_bcd;
    logic              w_done;
    logic              w_commit;
    int                w_sig;
    logic              w_ovf;
    logic              r_disp_neg;
    logic [4*NB-1:0]   r_disp_bcd;
    logic              r_disp_ovf;
    logic [TW-1:0]     r_tick;
    logic [DW-1:0]     r_dig;
    logic [3:0]        w_digit;
    logic [DIGITS-1:0] w_an;
    logic [6:0]        w_seg;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;

    assign w_accept = in_valid && r_ready;
    assign w_neg    = in_data[WIDTH-1];
    // WIDTH-bit unsigned magnitude, so the most negative value maps to 2^(WIDTH-1).
    assign w_mag    = w_neg ? (~in_data + WIDTH'(1'b1)) : in_data;
    assign w_commit = (r_state == ST_COMMIT) && w_done;

    sseg_bin2bcd #(.WIDTH(WIDTH)) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_accept),
        .bin   (w_mag),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    // Next-state logic for the accept/convert/commit sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_shift_cnt == CW'(WIDTH - 1)) begin
                    w_next_state = ST_COMMIT;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_COMMIT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // FSM state, handshake ready and shift-step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_shift_cnt <= {CW{1'b0}};
            r_neg_pend  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == ST_IDLE);
            if (w_accept) begin
                r_shift_cnt <= {CW{1'b0}};
                r_neg_pend  <= w_neg;
            end else if (r_state == ST_SHIFT) begin
                r_shift_cnt <= r_shift_cnt + CW'(1'b1);
            end
        end
    end

    // Significant-digit count of the finished conversion decides overflow.
    always_comb begin
        w_sig = 0;
        for (int i = 0; i < NB; i++) begin
            w_sig = (w_bcd[4*i +: 4] != 4'd0) ? (i + 1) : w_sig;
        end
        if (r_neg_pend) begin
            w_ovf = (w_sig > DIGITS - 1);
        end else begin
            w_ovf = (w_sig > DIGITS);
        end
    end

    // Display register; only ever loaded as a whole at commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_neg <= 1'b0;
            r_disp_bcd <= {(4*NB){1'b0}};
            r_disp_ovf <= 1'b0;
        end else if (w_commit) begin
            r_disp_neg <= r_neg_pend;
            r_disp_bcd <= w_bcd;
            r_disp_ovf <= w_ovf;
        end
    end

    // Scan timing: each digit slot lasts SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= {TW{1'b0}};
            r_dig  <= {DW{1'b0}};
        end else if (r_tick == TW'(SCAN_DIV - 1)) begin
            r_tick <= {TW{1'b0}};
            r_dig  <= (r_dig == DW'(DIGITS - 1)) ? {DW{1'b0}} : (r_dig + DW'(1'b1));
        end else begin
            r_tick <= r_tick + TW'(1'b1);
        end
    end

    // Glyph and anode selection for the digit currently being scanned.
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < NB; i++) begin
            w_digit = (i == int'(r_dig)) ? r_disp_bcd[4*i +: 4] : w_digit;
        end
        for (int i = 0; i < DIGITS; i++) begin
            w_an[i] = (i != int'(r_dig));
        end
`ifdef SSEG_LZ_BLANK_EN
        begin : g_blank
            int msd;
            msd = 0;
            for (int i = 0; i < NB; i++) begin
                msd = (r_disp_bcd[4*i +: 4] != 4'd0) ? i : msd;
            end
            if (r_disp_ovf) begin
                w_seg = SEG_DASH;
            end else if (int'(r_dig) <= msd) begin
                w_seg = bcd_to_seg(w_digit);
            end else if (r_disp_neg && (int'(r_dig) == msd + 1)) begin
                w_seg = SEG_MINUS;
            end else begin
                w_seg = SEG_BLANK;
            end
        end
`else
        if (r_disp_ovf) begin
            w_seg = SEG_DASH;
        end else if (r_disp_neg && (int'(r_dig) == DIGITS - 1)) begin
            w_seg = SEG_MINUS;
        end else begin
            w_seg = bcd_to_seg(w_digit);
        end
`endif
    end

    // Anode and segment outputs switch together on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= {DIGITS{1'b1}};
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign in_ready = r_ready;
    assign an       = r_an;
    assign seg      = r_seg;

endmodule
